// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Brief    : NUM_REGS x WIDTH register file with IR-field select, byte-lane
//            write masking, tristate bus drive and a sticky conflict flag.
// Revision : 1.0
// ============================================================================
module register_bank #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int R0_ZERO  = 1
) (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic [WIDTH-1:0]     BusMuxOut,
    input  logic [ADDR_W-1:0]    IR_ra,
    input  logic [ADDR_W-1:0]    IR_rb,
    input  logic [ADDR_W-1:0]    IR_rc,
    input  logic                 Gra,
    input  logic                 Grb,
    input  logic                 Grc,
    input  logic                 Rin,
    input  logic                 Rout,
    input  logic                 BAout,
    input  logic [WIDTH/8-1:0]   ByteEn,
    input  logic                 ErrClr,
    output logic [WIDTH-1:0]     BusMuxIn,
    output logic                 ConflictErr
);

    localparam int c_LANES = WIDTH / 8;

    logic [WIDTH-1:0]  r_regs [NUM_REGS];
    logic              r_err;

    logic [ADDR_W-1:0] w_sel;
    logic              w_sel_valid;
    logic              w_any_ctrl;
    logic              w_multi_sel;
    logic              w_conflict;
    logic              w_drive;
    logic              w_force_zero;
    logic [WIDTH-1:0]  w_rd_data;

    always_comb begin
        w_sel = IR_rc;
        if (Gra) begin
            w_sel = IR_ra;
        end else if (Grb) begin
            w_sel = IR_rb;
        end
    end

    assign w_sel_valid  = Gra | Grb | Grc;
    assign w_any_ctrl   = Rin | Rout | BAout;
    assign w_multi_sel  = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    assign w_conflict   = (Rout & BAout)
                        | (w_multi_sel & w_any_ctrl)
                        | (w_any_ctrl & ~w_sel_valid);

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (Rin && w_sel_valid) begin
            for (int l = 0; l < c_LANES; l++) begin
                if (ByteEn[l]) begin
                    r_regs[w_sel][8*l +: 8] <= BusMuxOut[8*l +: 8];
                end
            end
        end
    end

    // A fresh conflict wins over a same-cycle clear so no event is lost.
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            r_err <= 1'b0;
        end else if (w_conflict) begin
            r_err <= 1'b1;
        end else if (ErrClr) begin
            r_err <= 1'b0;
        end
    end

    assign w_rd_data    = r_regs[w_sel];
    assign w_drive      = w_sel_valid & (Rout | BAout);
    assign w_force_zero = (R0_ZERO != 0) && BAout && !Rout && (w_sel == '0);

    assign BusMuxIn    = w_drive ? (w_force_zero ? '0 : w_rd_data) : {WIDTH{1'bz}};
    assign ConflictErr = r_err;

endmodule
`default_nettype wire
